// File: rtl/line_clear.sv
// Board register and line-clear sequencer for a 20x10 falling-block playfield.
// Optional scoring is enabled by defining LINE_CLEAR_SCORE_EN.
module line_clear (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [0:199]   comb_in,
   output logic [0:199]   static_out,
   output logic           busy,
   output logic           done,
   output logic [2:0]     lines,
   output logic           overflow,
   output logic [15:0]    score
);

   typedef enum logic [1:0] {StIdle, StScan, StDone} state_t;

   state_t         r_state;
   logic [0:199]   r_board;
   logic [4:0]     r_row;
   logic [2:0]     r_lines;
   logic           r_overflow;

   state_t         w_state_nxt;
   logic [0:199]   w_board_nxt;
   logic [4:0]     w_row_nxt;
   logic [2:0]     w_lines_nxt;
   logic           w_overflow_nxt;
   logic [7:0]     w_base;
   logic           w_row_full;
   logic [0:199]   w_shifted;

   always_comb begin
      w_base     = r_row * 8'd10;
      w_row_full = &r_board[w_base +: 10];

      // Every row at or above the current one drops by one; rows below stay put.
      w_shifted       = r_board;
      w_shifted[0:9]  = 10'd0;
      for (int i = 1; i < 20; i++) begin
         if (5'(i) <= r_row) begin
            w_shifted[i*10 +: 10] = r_board[(i-1)*10 +: 10];
         end
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_board_nxt    = r_board;
      w_row_nxt      = r_row;
      w_lines_nxt    = r_lines;
      w_overflow_nxt = r_overflow;
      unique case (r_state)
         StIdle: begin
            if (start) begin
               w_board_nxt = comb_in;
               w_lines_nxt = 3'd0;
               w_row_nxt   = 5'd19;
               w_state_nxt = StScan;
            end
         end
         StScan: begin
            if (w_row_full) begin
               w_board_nxt = w_shifted;
               if (r_lines != 3'd7) begin
                  w_lines_nxt = r_lines + 3'd1;
               end
            end else if (r_row != 5'd0) begin
               w_row_nxt = r_row - 5'd1;
            end else begin
               w_state_nxt = StDone;
            end
         end
         StDone: begin
            w_overflow_nxt = |r_board[0:9];
            w_state_nxt    = StIdle;
         end
         default: w_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= StIdle;
         r_board    <= '0;
         r_row      <= 5'd0;
         r_lines    <= 3'd0;
         r_overflow <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_board    <= w_board_nxt;
         r_row      <= w_row_nxt;
         r_lines    <= w_lines_nxt;
         r_overflow <= w_overflow_nxt;
      end
   end

`ifdef LINE_CLEAR_SCORE_EN
   logic [15:0] r_score;
   logic [9:0]  w_score_add;
   logic [16:0] w_score_sum;

   always_comb begin
      case (r_lines)
         3'd1:    w_score_add = 10'd100;
         3'd2:    w_score_add = 10'd300;
         3'd3:    w_score_add = 10'd500;
         3'd4:    w_score_add = 10'd800;
         default: w_score_add = 10'd0;
      endcase
      w_score_sum = {1'b0, r_score} + {7'd0, w_score_add};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_score <= 16'd0;
      end else if (r_state == StDone) begin
         r_score <= w_score_sum[16] ? 16'hffff : w_score_sum[15:0];
      end
   end

   assign score = r_score;
`else
   assign score = 16'd0;
`endif

   assign static_out = r_board;
   assign busy       = (r_state != StIdle);
   assign done       = (r_state == StDone);
   assign lines      = r_lines;
   assign overflow   = r_overflow;

endmodule

// File: tb/tb_line_clear.sv
// Self-checking bench for line_clear: row-compaction model plus directed scenarios.
// Score expectations follow LINE_CLEAR_SCORE_EN.
module tb_line_clear;

   typedef logic [0:199] board_t;

   logic          clk;
   logic          rst;
   logic          start;
   board_t        comb_in;
   board_t        static_out;
   logic          busy;
   logic          done;
   logic [2:0]    lines;
   logic          overflow;
   logic [15:0]   score;

   int n_cmp = 0;
   int n_err = 0;

   line_clear dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .comb_in    (comb_in),
      .static_out (static_out),
      .busy       (busy),
      .done       (done),
      .lines      (lines),
      .overflow   (overflow),
      .score      (score)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk_i(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic chk_b(input string name, input board_t got, input board_t exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Result of an operation: full rows vanish, the rest settle to the bottom in order.
   function automatic board_t clear_model(input board_t b, output int k);
      board_t res;
      int     w;
      res = '0;
      w   = 19;
      k   = 0;
      for (int r = 19; r >= 0; r--) begin
         if (&b[r*10 +: 10]) begin
            k++;
         end else begin
            res[w*10 +: 10] = b[r*10 +: 10];
            w--;
         end
      end
      return res;
   endfunction

   function automatic int score_add(input int k);
      case (k)
         1:       return 100;
         2:       return 300;
         3:       return 500;
         4:       return 800;
         default: return 0;
      endcase
   endfunction

   // Model state: cycles until back in idle, plus the values visible once idle.
   int     m_left  = 0;
   int     m_k     = 0;
   board_t m_pend  = '0;
   board_t m_board = '0;
   int     m_lines = 0;
   int     m_ovf   = 0;
   int     m_score = 0;
   bit     cmp_en  = 0;

   always @(posedge clk) begin
      if (rst) begin
         m_left  = 0;
         m_board = '0;
         m_lines = 0;
         m_ovf   = 0;
         m_score = 0;
      end else if (m_left > 0) begin
         m_left--;
         if (m_left == 0) begin
            m_board = m_pend;
            m_lines = (m_k > 7) ? 7 : m_k;
            m_ovf   = |m_pend[0:9] ? 1 : 0;
`ifdef LINE_CLEAR_SCORE_EN
            m_score = m_score + score_add(m_lines);
            if (m_score > 65535) m_score = 65535;
`endif
         end
      end else if (start) begin
         m_pend = clear_model(comb_in, m_k);
         m_left = 21 + m_k;
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk_i("busy", 32'(busy), 32'(m_left > 0));
         chk_i("done", 32'(done), 32'(m_left == 1));
         if (m_left == 0) begin
            chk_b("static_out", static_out, m_board);
            chk_i("lines", 32'(lines), 32'(m_lines));
            chk_i("overflow", 32'(overflow), 32'(m_ovf));
            chk_i("score", 32'(score), 32'(m_score));
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Returns negedges from the start cycle to the done cycle; ends one cycle after done.
   task automatic run_op(input board_t v, output int lat);
      @(negedge clk);
      comb_in = v;
      start   = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      comb_in = ~v;
      lat     = 1;
      while (done !== 1'b1 && lat < 60) begin
         @(negedge clk);
         lat++;
      end
      if (done !== 1'b1) begin
         n_cmp++;
         n_err++;
         $display("FAIL done_timeout: got no done expected done within 60 cycles");
      end
      @(negedge clk);
   endtask

   board_t v;
   board_t e;
   int     lat;
   int     done_seen;
   int     exp_sc;

   initial begin
      rst     = 1'b1;
      start   = 1'b0;
      comb_in = '0;
      @(negedge clk);
      @(negedge clk);
      rst    = 1'b0;
      cmp_en = 1;
      @(negedge clk);
      chk_b("reset_board", static_out, '0);
      chk_i("reset_busy", 32'(busy), 32'd0);
      chk_i("reset_lines", 32'(lines), 32'd0);
      chk_i("reset_score", 32'(score), 32'd0);

      // Empty board
      run_op('0, lat);
      chk_i("empty_latency", 32'(lat), 32'd21);
      chk_i("empty_lines", 32'(lines), 32'd0);
      chk_i("empty_overflow", 32'(overflow), 32'd0);
      chk_b("empty_board", static_out, '0);

      // Single bottom row plus one block above it
      do_reset();
      v = '0;
      v[190:199] = '1;
      v[185] = 1'b1;
      run_op(v, lat);
      e = '0;
      e[195] = 1'b1;
      chk_i("one_latency", 32'(lat), 32'd22);
      chk_i("one_lines", 32'(lines), 32'd1);
      chk_b("one_board", static_out, e);
`ifdef LINE_CLEAR_SCORE_EN
      exp_sc = 100;
`else
      exp_sc = 0;
`endif
      chk_i("one_score", 32'(score), 32'(exp_sc));

      // Four full rows, block drops four rows
      do_reset();
      v = '0;
      v[160:199] = '1;
      v[0] = 1'b1;
      run_op(v, lat);
      e = '0;
      e[40] = 1'b1;
      chk_i("four_latency", 32'(lat), 32'd25);
      chk_i("four_lines", 32'(lines), 32'd4);
      chk_b("four_board", static_out, e);
`ifdef LINE_CLEAR_SCORE_EN
      exp_sc = 800;
`else
      exp_sc = 0;
`endif
      chk_i("four_score", 32'(score), 32'(exp_sc));

      // Non-adjacent full rows with a partial row between them
      v = '0;
      v[170:179] = '1;
      v[190:199] = '1;
      v[180:184] = '1;
      run_op(v, lat);
      e = '0;
      e[190:194] = '1;
      chk_i("split_lines", 32'(lines), 32'd2);
      chk_b("split_board", static_out, e);

      // Top row occupied: overflow, then cleared by an empty operation
      v = '0;
      v[3] = 1'b1;
      run_op(v, lat);
      chk_i("ovf_set", 32'(overflow), 32'd1);
      chk_i("ovf_lines", 32'(lines), 32'd0);
      run_op('0, lat);
      chk_i("ovf_clear", 32'(overflow), 32'd0);

      // Full top row is cleared too
      v = '0;
      v[0:9] = '1;
      run_op(v, lat);
      chk_i("top_latency", 32'(lat), 32'd22);
      chk_b("top_board", static_out, '0);

      // Start raised during the done cycle is dropped
      @(negedge clk);
      comb_in = '0;
      start   = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      lat     = 1;
      while (done !== 1'b1 && lat < 60) begin
         @(negedge clk);
         lat++;
      end
      comb_in = '1;
      start   = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      chk_i("start_on_done_ignored", 32'(busy), 32'd0);
      @(negedge clk);

      // Abort with reset five cycles into the scan
      v = '0;
      v[190:199] = '1;
      v[185] = 1'b1;
      comb_in = v;
      start   = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      done_seen = 0;
      repeat (30) begin
         @(negedge clk);
         if (done === 1'b1) done_seen++;
      end
      chk_i("abort_no_done", 32'(done_seen), 32'd0);
      chk_b("abort_board", static_out, '0);
      chk_i("abort_busy", 32'(busy), 32'd0);
      chk_i("abort_lines", 32'(lines), 32'd0);
      chk_i("abort_overflow", 32'(overflow), 32'd0);
      chk_i("abort_score", 32'(score), 32'd0);

      // Start while busy has no effect on the running operation
      @(negedge clk);
      comb_in = v;
      start   = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      comb_in = '1;
      start   = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat   = 0;
      while (busy === 1'b1 && lat < 60) begin
         @(negedge clk);
         lat++;
      end
      e = '0;
      e[195] = 1'b1;
      chk_i("busy_start_lines", 32'(lines), 32'd1);
      chk_b("busy_start_board", static_out, e);
      chk_i("busy_start_idle", 32'(busy), 32'd0);

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/line_clear.md
LINE_CLEAR -- requirements
Module: line_clear

Interface
REQ-001 The block SHALL have exactly these ports:
- clk  input  1  100MHz system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle request to lock comb_in and clear full rows
- comb_in  input  [0:199]  combined board image (static plus landed piece)
- static_out  output  [0:199]  registered static board for the combiner and display
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when an operation completes
- lines  output  [2:0]  rows cleared by the last operation, 0-4
- overflow  output  1  row 0 occupied after the last operation (game-over indication)
- score  output  [15:0]  accumulated score (see Configuration)
REQ-002 Board layout SHALL be 20 rows by 10 columns; bit index r*10+c is row r (0 = top), column c (0 = left).
REQ-003 A row SHALL be full when all 10 of its bits are 1.

Function
REQ-004 The FSM SHALL have three states: IDLE, SCAN, DONE.
REQ-005 In IDLE with start=1, the block SHALL load comb_in into the board register, clear lines, set row index to 19, and enter SCAN on the next edge.
REQ-006 start SHALL be ignored in SCAN and DONE; comb_in SHALL be sampled only in the cycle start is accepted.
REQ-007 In SCAN, if the current row is full, rows 0 to row-1 SHALL each shift down one row, row 0 SHALL be zero-filled, lines SHALL increment, and the row index SHALL stay unchanged.
REQ-008 In SCAN, if the current row is not full and row>0, the row index SHALL decrement by 1.
REQ-009 In SCAN, if the current row is not full and row=0, the FSM SHALL enter DONE.
REQ-010 SCAN SHALL last exactly 20+k cycles, where k is the number of rows cleared; a full row 0 SHALL be cleared and then rechecked as empty.
REQ-011 In DONE, done SHALL be 1 for exactly one cycle; overflow SHALL be updated to the OR of row 0 bits; the FSM SHALL return to IDLE.
REQ-012 busy SHALL be 1 in SCAN and DONE and 0 in IDLE.
REQ-013 static_out SHALL always reflect the board register, including intermediate shifts during SCAN; consumers sample it only while busy=0.
REQ-014 lines SHALL hold its value from DONE until the next accepted start; it SHALL never exceed 4 for legal piece placements and SHALL saturate at 7.
REQ-015 A start asserted in the same cycle as done SHALL be ignored; a start in the following IDLE cycle SHALL be accepted.

Reset
REQ-016 rst=1 SHALL force state IDLE, board all zero, busy=0, done=0, lines=0, overflow=0, and score=0 on the next edge.
REQ-017 rst SHALL take priority over start and over any in-progress SCAN; an aborted operation SHALL produce no done pulse.

Configuration
REQ-018 Macro LINE_CLEAR_SCORE_EN SHALL control scoring.
REQ-019 When LINE_CLEAR_SCORE_EN is defined, in DONE the block SHALL add 0/100/300/500/800 to score for lines=0/1/2/3/4, saturating at 65535.
REQ-020 When LINE_CLEAR_SCORE_EN is not defined, score SHALL be constant 0 and no score logic SHALL be synthesized.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Reset, then start with comb_in=0: done occurs 21 cycles after start, lines=0, overflow=0, static_out=0.
- Row 19 all ones and bit 185 set: lines=1, done 22 cycles after start, static_out has only bit 195 set; with the macro defined, score=100.
- Rows 16-19 full and bit 0 set: lines=4, static_out has only bit 40 set; with the macro defined, score=800; SCAN lasts 24 cycles.
- Rows 17 and 19 full, row 18 = bits 180-184: lines=2, and row 19 of the result holds bits 190-194 only.
- Bit 3 set with no full rows: overflow=1 after done; a second start with comb_in=0 gives overflow=0.
- rst pulsed 5 cycles into SCAN: no done pulse, all outputs zero; a start issued while busy=1 leaves lines unchanged.
